arty100t_shell: RTL and testbench

ARTY100T_SHELL -- requirements
Module: arty100t_shell

---
 rtl/arty100t_shell.sv | 217 +++++++++++++++++++++
 tb/tb_arty100t_shell.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arty100t_shell.sv
// Arty A7-100T shell: UART echo (8N1), heartbeat/status LEDs and a single-bit
// link on the JD header that captures jd_7 on each rising edge of jd_2.
module arty100t_shell #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int HB_BITS    = 26
) (
  input  logic CLK100MHZ,
  input  logic ck_rst,
  input  logic uart_txd_in,
  output logic uart_rxd_out,
  output logic led0_b,
  output logic led1_b,
  output logic led2_b,
  output logic jd_0,
  input  logic jd_1,
  input  logic jd_2,
  output logic jd_3,
  input  logic jd_4,
  input  logic jd_5,
  input  logic jd_6,
  input  logic jd_7
);

  localparam int DIV  = CLOCK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DIV_LAST  = cnt_t'(DIV - 1);
  localparam cnt_t HALF_LAST = cnt_t'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic w_unused;
  assign w_unused = &{1'b0, jd_1, jd_4, jd_5, jd_6};

  // Stage p0/p1: two-flop synchronizers; p2 of the link clock is its previous value
  logic r_rx_p0, r_rx_p1;
  logic r_lclk_p0, r_lclk_p1, r_lclk_p2;
  logic r_ldat_p0, r_ldat_p1;
  logic r_jd3;
  logic [HB_BITS-1:0] r_hb;

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      r_rx_p0   <= 1'b1;
      r_rx_p1   <= 1'b1;
      r_lclk_p0 <= 1'b0;
      r_lclk_p1 <= 1'b0;
      r_lclk_p2 <= 1'b0;
      r_ldat_p0 <= 1'b0;
      r_ldat_p1 <= 1'b0;
      r_jd3     <= 1'b0;
      r_hb      <= '0;
    end else begin
      r_rx_p0   <= uart_txd_in;
      r_rx_p1   <= r_rx_p0;
      r_lclk_p0 <= jd_2;
      r_lclk_p1 <= r_lclk_p0;
      r_lclk_p2 <= r_lclk_p1;
      r_ldat_p0 <= jd_7;
      r_ldat_p1 <= r_ldat_p0;
      if (r_lclk_p1 && !r_lclk_p2) r_jd3 <= r_ldat_p1;
      r_hb      <= r_hb + 1'b1;
    end
  end

  assign jd_0   = r_lclk_p1;
  assign jd_3   = r_jd3;
  assign led0_b = r_hb[HB_BITS-1];

  // Receiver: start bit rechecked at mid-bit, then data and stop sampled every DIV
  state_t     r_rx_st, w_rx_st;
  cnt_t       r_rx_cnt, w_rx_cnt;
  logic [2:0] r_rx_bit, w_rx_bit;
  logic [7:0] r_rx_sh, w_rx_sh;
  logic       w_rx_vld, w_rx_ferr;

  always_comb begin
    w_rx_st   = r_rx_st;
    w_rx_cnt  = r_rx_cnt + 1'b1;
    w_rx_bit  = r_rx_bit;
    w_rx_sh   = r_rx_sh;
    w_rx_vld  = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt = '0;
        if (!r_rx_p1) w_rx_st = S_START;
      end
      S_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt = '0;
          w_rx_bit = '0;
          w_rx_st  = r_rx_p1 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == DIV_LAST) begin
          w_rx_cnt = '0;
          w_rx_sh  = {r_rx_p1, r_rx_sh[7:1]};
          w_rx_bit = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_st = S_STOP;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == DIV_LAST) begin
          w_rx_cnt  = '0;
          w_rx_st   = S_IDLE;
          w_rx_vld  = r_rx_p1;
          w_rx_ferr = !r_rx_p1;
        end
      end
      default: w_rx_st = S_IDLE;
    endcase
  end

  // Transmitter: the line register is loaded with the next bit value, so each bit lasts DIV cycles
  state_t     r_tx_st, w_tx_st;
  cnt_t       r_tx_cnt, w_tx_cnt;
  logic [2:0] r_tx_bit, w_tx_bit;
  logic [7:0] r_tx_sh, w_tx_sh;
  logic       r_txd, w_txd;
  logic       w_tx_load;
  logic [7:0] r_hold;
  logic       r_hold_full;

  always_comb begin
    w_tx_st   = r_tx_st;
    w_tx_cnt  = r_tx_cnt + 1'b1;
    w_tx_bit  = r_tx_bit;
    w_tx_sh   = r_tx_sh;
    w_txd     = r_txd;
    w_tx_load = 1'b0;
    case (r_tx_st)
      S_IDLE: begin
        w_tx_cnt = '0;
        w_txd    = 1'b1;
        if (r_hold_full) begin
          w_tx_load = 1'b1;
          w_tx_sh   = r_hold;
          w_txd     = 1'b0;
          w_tx_st   = S_START;
        end
      end
      S_START: begin
        if (r_tx_cnt == DIV_LAST) begin
          w_tx_cnt = '0;
          w_tx_bit = '0;
          w_txd    = r_tx_sh[0];
          w_tx_st  = S_DATA;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == DIV_LAST) begin
          w_tx_cnt = '0;
          if (r_tx_bit == 3'd7) begin
            w_txd   = 1'b1;
            w_tx_st = S_STOP;
          end else begin
            w_tx_bit = r_tx_bit + 3'd1;
            w_tx_sh  = {1'b0, r_tx_sh[7:1]};
            w_txd    = r_tx_sh[1];
          end
        end
      end
      S_STOP: begin
        if (r_tx_cnt == DIV_LAST) begin
          w_tx_cnt = '0;
          w_tx_st  = S_IDLE;
        end
      end
      default: w_tx_st = S_IDLE;
    endcase
  end

  // State/control registers; a new RX byte wins over a simultaneous TX load of the holding register
  logic r_led1, r_led2;

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      r_rx_st     <= S_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_tx_st     <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_txd       <= 1'b1;
      r_hold_full <= 1'b0;
      r_led1      <= 1'b0;
      r_led2      <= 1'b0;
    end else begin
      r_rx_st  <= w_rx_st;
      r_rx_cnt <= w_rx_cnt;
      r_rx_bit <= w_rx_bit;
      r_tx_st  <= w_tx_st;
      r_tx_cnt <= w_tx_cnt;
      r_tx_bit <= w_tx_bit;
      r_txd    <= w_txd;
      if (w_rx_vld)       r_hold_full <= 1'b1;
      else if (w_tx_load) r_hold_full <= 1'b0;
      if (w_rx_vld)  r_led1 <= ~r_led1;
      if (w_rx_ferr) r_led2 <= 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    r_rx_sh <= w_rx_sh;
    r_tx_sh <= w_tx_sh;
    if (w_rx_vld) r_hold <= r_rx_sh;
  end

  assign uart_rxd_out = r_txd;
  assign led1_b       = r_led1;
  assign led2_b       = r_led2;

endmodule

// File: tb/tb_arty100t_shell.sv
// Bench for arty100t_shell: reset, heartbeat, link capture, UART echo via
// a frame monitor feeding a scoreboard, framing error and mid-echo reset.
`timescale 1ns/1ps
module tb_arty100t_shell;

  localparam int CF  = 3_200_000;
  localparam int BR  = 100_000;
  localparam int DIV = CF / BR;

  logic clk = 1'b0;
  logic ck_rst, uart_txd_in, uart_rxd_out;
  logic led0_b, led1_b, led2_b;
  logic jd_0, jd_1, jd_2, jd_3, jd_4, jd_5, jd_6, jd_7;

  arty100t_shell #(.CLOCK_FREQ(CF), .BAUD(BR), .HB_BITS(4)) dut (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .uart_txd_in(uart_txd_in),
    .uart_rxd_out(uart_rxd_out), .led0_b(led0_b), .led1_b(led1_b),
    .led2_b(led2_b), .jd_0(jd_0), .jd_1(jd_1), .jd_2(jd_2), .jd_3(jd_3),
    .jd_4(jd_4), .jd_5(jd_5), .jd_6(jd_6), .jd_7(jd_7)
  );

  always #5 clk = ~clk;

  int vec_n = 0;
  int miss_n = 0;

  typedef struct {
    logic [7:0] data;
    logic       ok;
  } frm_t;

  frm_t       act_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_echo;
    logic       exp_led1;
    logic       exp_led2;
  } vec_t;

  vec_t vt[6];
  logic h[0:399];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Serial monitor on uart_rxd_out: samples mid-bit, flags start/stop or bit-timing errors
  int         m_cnt;
  logic       m_busy = 1'b0;
  logic       m_prev;
  logic       m_ok;
  logic [7:0] m_sh;

  always @(negedge clk) begin
    if (ck_rst === 1'b1) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (uart_rxd_out === 1'b0) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_ok   = 1'b1;
        m_prev = 1'b0;
      end
    end else begin
      m_cnt++;
      if (uart_rxd_out !== m_prev && (m_cnt % DIV) != 0) m_ok = 1'b0;
      m_prev = uart_rxd_out;
      if (m_cnt == DIV/2 && uart_rxd_out !== 1'b0) m_ok = 1'b0;
      if (m_cnt > DIV/2 && m_cnt < DIV/2 + 9*DIV && ((m_cnt - DIV/2) % DIV) == 0)
        m_sh = {uart_rxd_out, m_sh[7:1]};
      if (m_cnt == DIV/2 + 9*DIV && uart_rxd_out !== 1'b1) m_ok = 1'b0;
      if (m_cnt == 10*DIV - 1) begin
        act_q.push_back('{m_sh, m_ok});
        m_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(posedge clk); #1 uart_txd_in = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_txd_in = b[i];
      repeat (DIV) @(posedge clk);
    end
    #1 uart_txd_in = stop_ok;
    repeat (stop_ok ? DIV : (3*DIV)/4) @(posedge clk);
    #1 uart_txd_in = 1'b1;
  endtask

  task automatic drain(input string nm);
    int   t = 0;
    frm_t f;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      while (act_q.size() == 0 && t < 14*DIV) begin
        @(negedge clk);
        t++;
      end
      e = exp_q.pop_front();
      chk({nm, "_present"}, act_q.size(), 1);
      if (act_q.size() != 0) begin
        f = act_q.pop_front();
        chk({nm, "_data"}, f.data, e);
        chk({nm, "_frame"}, f.ok, 1'b1);
      end
    end
    repeat (12*DIV) @(negedge clk);
    chk({nm, "_no_extra_frame"}, act_q.size(), 0);
    act_q.delete();
  endtask

  task automatic link_pulse();
    repeat (20) @(posedge clk);
    #1 jd_7 = 1'b1;
    repeat (10) @(posedge clk);
    #1 jd_2 = 1'b1;
    repeat (20) @(posedge clk);
    #1 jd_2 = 1'b0;
    jd_7 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_a, err_b, err_c, err_d, t;
    logic got;

    vt[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[1] = '{8'hA3, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1};

    ck_rst = 1'b1; uart_txd_in = 1'b1;
    jd_1 = 1'b0; jd_2 = 1'b0; jd_4 = 1'b0; jd_5 = 1'b0; jd_6 = 1'b0; jd_7 = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_rxd_out", uart_rxd_out, 1'b1);
    chk("rst_led0", led0_b, 1'b0);
    chk("rst_led1", led1_b, 1'b0);
    chk("rst_led2", led2_b, 1'b0);
    chk("rst_jd0", jd_0, 1'b0);
    chk("rst_jd3", jd_3, 1'b0);

    @(posedge clk); #1 ck_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      chk("heartbeat", led0_b, ((k % 16) >= 8));
    end

    err_a = 0; err_b = 0; err_c = 0; err_d = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (n % 20 == 0) jd_2 = ~jd_2;
      @(negedge clk);
      h[n] = jd_2;
      if (uart_rxd_out !== 1'b1) err_a++;
      if (led1_b !== 1'b0 || led2_b !== 1'b0) err_b++;
      if (jd_3 !== 1'b0) err_c++;
      if (n >= 2 && jd_0 !== h[n-2]) err_d++;
    end
    chk("idle_uart_line", err_a, 0);
    chk("idle_leds", err_b, 0);
    chk("idle_jd3", err_c, 0);
    chk("idle_jd0_lag", err_d, 0);

    @(posedge clk); #1 jd_7 = 1'b1;
    repeat (10) @(posedge clk);
    #1 jd_2 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (jd_3 === 1'b1) got = 1'b1;
    end
    chk("link_capture_1", jd_3, 1'b1);
    repeat (5) @(posedge clk);
    #1 jd_7 = 1'b0;
    err_a = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (jd_3 !== 1'b1) err_a++;
    end
    @(posedge clk); #1 jd_2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (jd_3 !== 1'b1) err_a++;
    end
    chk("link_hold", err_a, 0);
    @(posedge clk); #1 jd_2 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (jd_3 === 1'b0) got = 1'b1;
    end
    chk("link_capture_0", jd_3, 1'b0);
    repeat (20) @(posedge clk);
    #1 jd_2 = 1'b0;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].exp_echo) exp_q.push_back(vt[i].data);
      send_byte(vt[i].data, vt[i].stop_ok);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_led1", i), led1_b, vt[i].exp_led1);
      chk($sformatf("vec%0d_led2", i), led2_b, vt[i].exp_led2);
      drain($sformatf("vec%0d_echo", i));
    end

    send_byte(8'h5A, 1'b1);
    t = 0;
    while (uart_rxd_out !== 1'b0 && t < 4*DIV) begin
      @(negedge clk);
      t++;
    end
    chk("abort_echo_started", uart_rxd_out, 1'b0);
    repeat (3*DIV) @(posedge clk);
    #1 ck_rst = 1'b1;
    @(posedge clk);
    #1 ck_rst = 1'b0;
    @(negedge clk);
    chk("abort_uart_high", uart_rxd_out, 1'b1);
    chk("abort_led1", led1_b, 1'b0);
    chk("abort_led2", led2_b, 1'b0);
    err_a = 0;
    for (int i = 0; i < 12*DIV; i++) begin
      @(negedge clk);
      if (uart_rxd_out !== 1'b1) err_a++;
    end
    chk("abort_quiet", err_a, 0);
    chk("abort_no_frame", act_q.size(), 0);
    act_q.delete();

    exp_q.push_back(8'hC7);
    fork
      send_byte(8'hC7, 1'b1);
      link_pulse();
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("concurrent_led1", led1_b, 1'b1);
    chk("concurrent_jd3", jd_3, 1'b1);
    drain("concurrent_echo");

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
